// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operand channel in, result channel out.
// master = producer/consumer side, slave = the adder.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic                    cin;
    logic                    op;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] sum;
    logic                    cout;
    logic                    ovf;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// Sliced add/subtract pipeline (STAGES slices, one register per slice, global stall).
// Optional macro ADDER_SAT_EN clamps the result to the signed range on overflow.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    pipe_adder_if.slave bus
);
    // WIDTH must be a multiple of STAGES
    localparam int SLICE = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;

    logic w_advance;

`ifdef ADDER_SAT_EN
    function automatic logic signed [WIDTH-1:0] sat_clamp(
        input logic signed [WIDTH-1:0] raw,
        input logic                    ovf,
        input logic                    a_msb
    );
        logic signed [WIDTH-1:0] lim;
        lim = a_msb ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        return ovf ? lim : raw;
    endfunction
`endif

    assign w_advance     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready  = w_advance;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic signed [WIDTH-1:0] w_a;
        logic signed [WIDTH-1:0] w_b;
        logic signed [WIDTH-1:0] w_sum_in;
        logic signed [WIDTH-1:0] w_sum;
        logic                    w_c_in;
        logic                    w_vld_in;
        logic [SLICE:0]          w_slice;

        logic signed [WIDTH-1:0] r_sum_p;
        logic                    r_c_p;
        logic                    r_vld_p;

        if (s == 0) begin : g_head
            // subtract as a + ~b + ~cin so one adder serves both ops
            assign w_a      = bus.a;
            assign w_b      = bus.op ? ~bus.b : bus.b;
            assign w_c_in   = bus.cin ^ bus.op;
            assign w_sum_in = '0;
            assign w_vld_in = bus.in_valid;
        end else begin : g_body
            assign w_a      = g_stage[s-1].g_mid.r_a_p;
            assign w_b      = g_stage[s-1].g_mid.r_b_p;
            assign w_c_in   = g_stage[s-1].r_c_p;
            assign w_sum_in = g_stage[s-1].r_sum_p;
            assign w_vld_in = g_stage[s-1].r_vld_p;
        end

        assign w_slice = {1'b0, w_a[s*SLICE +: SLICE]}
                       + {1'b0, w_b[s*SLICE +: SLICE]}
                       + {{SLICE{1'b0}}, w_c_in};

        always_comb begin
            w_sum                   = w_sum_in;
            w_sum[s*SLICE +: SLICE] = w_slice[SLICE-1:0];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_vld_p <= 1'b0;
            end else if (w_advance) begin
                r_vld_p <= w_vld_in;
            end
        end

        if (s == STAGES - 1) begin : g_tail
            logic                    w_ovf;
            logic signed [WIDTH-1:0] w_res;
            logic                    r_ovf_p;

            assign w_ovf = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
`ifdef ADDER_SAT_EN
            assign w_res = sat_clamp(w_sum, w_ovf, w_a[MSB]);
`else
            assign w_res = w_sum;
`endif
            // ---- output stage: result registers are visible on the bus ----
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sum_p <= '0;
                    r_c_p   <= 1'b0;
                    r_ovf_p <= 1'b0;
                end else if (w_advance) begin
                    r_sum_p <= w_res;
                    r_c_p   <= w_slice[SLICE];
                    r_ovf_p <= w_ovf;
                end
            end
        end else begin : g_mid
            logic signed [WIDTH-1:0] r_a_p;
            logic signed [WIDTH-1:0] r_b_p;

            // ---- stage boundary: skewed operands, partial sum, slice carry ----
            always_ff @(posedge clk) begin
                if (w_advance) begin
                    r_a_p   <= w_a;
                    r_b_p   <= w_b;
                    r_sum_p <= w_sum;
                    r_c_p   <= w_slice[SLICE];
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].r_vld_p;
    assign bus.sum       = g_stage[STAGES-1].r_sum_p;
    assign bus.cout      = g_stage[STAGES-1].r_c_p;
    assign bus.ovf       = g_stage[STAGES-1].g_tail.r_ovf_p;
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: driver pushes model results, monitor pops on transfer.
module tb_pipe_adder;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
        int          stl;
    } exp_t;

    logic clk;
    logic rst;
    pipe_adder_if #(.WIDTH(WIDTH)) u_if();

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    exp_t q[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   edge_n  = 0;
    int   stall_n = 0;
    bit   or_rand = 0;
    int   hold_n  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic op);
        exp_t   e;
        longint ua, ub, sa, sb, c, ur, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = longint'(cin);
        if (!op) begin
            ur     = ua + ub + c;
            sr     = sa + sb + c;
            e.cout = (ur > 64'sd4294967295);
        end else begin
            ur     = ua - ub - c;
            sr     = sa - sb - c;
            e.cout = (ur >= 0);
        end
        e.sum = ur[31:0];
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef ADDER_SAT_EN
        if (e.ovf) e.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        e.acc = 0;
        e.stl = 0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (hold_n > 0) begin
            u_if.out_ready = 1'b0;
            hold_n--;
        end else begin
            u_if.out_ready = or_rand ? ($urandom_range(3) != 0) : 1'b1;
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic op, input bit must_now);
        int   tries = 0;
        bit   done  = 0;
        exp_t e;
        u_if.in_valid = 1'b1;
        u_if.a        = a;
        u_if.b        = b;
        u_if.cin      = cin;
        u_if.op       = op;
        while (!done) begin
            @(negedge clk);
            if (u_if.in_ready) begin
                e     = model(a, b, cin, op);
                e.acc = edge_n;
                e.stl = stall_n;
                q.push_back(e);
                done  = 1;
            end else if (++tries > 500) begin
                n_vec++;
                n_err++;
                $display("FAIL send_timeout: in_ready 0 for %0d cycles, expected 1", tries);
                done = 1;
            end
            step();
        end
        u_if.in_valid = 1'b0;
        if (must_now) check("in_ready_b2b", 32'(tries), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
            q.delete();
        end
        repeat (2) step();
    endtask

    // Monitor: handshake rules, stall stability, and in-order result checking.
    logic [31:0] prev_sum;
    bit          prev_stall = 0;
    exp_t        m_e;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 0;
        end else begin
            check("in_ready_rule", 32'(u_if.in_ready), 32'(!(u_if.out_valid && !u_if.out_ready)));
            if (prev_stall) begin
                check("stall_hold_valid", 32'(u_if.out_valid), 32'd1);
                check("stall_hold_sum", u_if.sum, prev_sum);
            end
            prev_stall = u_if.out_valid && !u_if.out_ready;
            prev_sum   = u_if.sum;
            if (u_if.out_valid && !u_if.out_ready) stall_n++;
            if (u_if.out_valid && u_if.out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: sum %h with nothing pending, expected no output", u_if.sum);
                end else begin
                    m_e = q.pop_front();
                    check("sum", u_if.sum, m_e.sum);
                    check("cout", 32'(u_if.cout), 32'(m_e.cout));
                    check("ovf", 32'(u_if.ovf), 32'(m_e.ovf));
                    check("latency", 32'(edge_n), 32'(m_e.acc + STAGES + (stall_n - m_e.stl)));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] edge_vals [6];
        logic [31:0] ra, rb;
        edge_vals = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_FFFF, 32'h00FF_FF00};

        rst            = 1'b1;
        u_if.in_valid  = 1'b0;
        u_if.a         = '0;
        u_if.b         = '0;
        u_if.cin       = 1'b0;
        u_if.op        = 1'b0;
        u_if.out_ready = 1'b1;
        #3 rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        check("rst_sum", u_if.sum, 32'd0);
        check("rst_cout", 32'(u_if.cout), 32'd0);
        check("rst_ovf", 32'(u_if.ovf), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rst_in_ready", 32'(u_if.in_ready), 32'd1);

        send(32'h8000_0001, 32'h8000_0002, 1'b0, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0);
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 10; i++) send(32'(i), 32'(i), 1'b0, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 4; i++) begin
            if (i == 3) hold_n = 3;
            send(32'(i + 20), 32'(i * 3), 1'b0, 1'b0, 1'b0);
        end
        drain();

        for (int i = 0; i < 6; i++) send(32'(i + 100), 32'(i + 100), 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(u_if.out_valid), 32'd0);
        check("arst_sum", u_if.sum, 32'd0);
        q.delete();
        repeat (2) step();
        rst = 1'b1;
        #1 check("arst_in_ready", 32'(u_if.in_ready), 32'd1);
        repeat (8) step();
        send(32'h0000_1234, 32'h0000_1111, 1'b1, 1'b0, 1'b1);
        drain();

        or_rand = 1;
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(5)] : $urandom;
            rb = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(5)] : $urandom;
            send(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
            repeat ($urandom_range(2) == 0 ? $urandom_range(2) : 0) step();
        end
        or_rand = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
